modexp_job_arbiter: RTL and testbench

- Shares one `modular_exp` engine between two requesters, e.g. the encrypt path and the decrypt/verify path.
- Accepts jobs of the form (base, exp, n) and grants them round-robin.
- Sequences the engine's start/ready handshake and returns each result to the requester that issued the job.
- Short-circuits degenerate operands without using the engine, and flags engine hangs with a watchdog.

---
 rtl/modexp_job_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_modexp_job_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : modexp_job_arbiter
// Description : Two-channel round-robin front end for a single modular_exp
//               engine. Degenerate jobs (n==0, exp==0) are answered locally;
//               a watchdog converts engine hangs into error responses.
// Revision    : 1.0 - initial release
// ============================================================================
module modexp_job_arbiter #(
  parameter int WIDTH   = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_base,
  input  logic [2*WIDTH-1:0] req_exp,
  input  logic [2*WIDTH-1:0] req_n,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               eng_start,
  output logic [WIDTH-1:0]   eng_base,
  output logic [WIDTH-1:0]   eng_exp,
  output logic [WIDTH-1:0]   eng_n,
  input  logic [WIDTH-1:0]   eng_result,
  input  logic               eng_ready
);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_ISSUE     = 3'd1;
  localparam logic [2:0] c_WAIT_BUSY = 3'd2;
  localparam logic [2:0] c_WAIT_DONE = 3'd3;
  localparam logic [2:0] c_RESP      = 3'd4;

  // Counter only needs to reach TIMEOUT-1.
  localparam int                c_WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic              r_rr;        // channel preferred on the next tie
  logic              r_grant;     // channel owning the job in flight
  logic [WIDTH-1:0]  r_base;
  logic [WIDTH-1:0]  r_exp;
  logic [WIDTH-1:0]  r_n;
  logic [WIDTH-1:0]  r_rsp_data;
  logic              r_rsp_err;
  logic [c_WD_W-1:0] r_wd;

  logic              w_grant;
  logic [WIDTH-1:0]  w_sel_base;
  logic [WIDTH-1:0]  w_sel_exp;
  logic [WIDTH-1:0]  w_sel_n;
  logic              w_n_zero;
  logic              w_e_zero;
  logic              w_degen;
  logic              w_accept;
  logic              w_timeout;

  // Round-robin winner: a lone requester wins, a tie goes to the preferred channel.
  always_comb begin
    w_grant = 1'b0;
    if (req_valid == 2'b11) begin
      w_grant = r_rr;
    end else if (req_valid[1]) begin
      w_grant = 1'b1;
    end
  end

  assign w_sel_base = w_grant ? req_base[2*WIDTH-1:WIDTH] : req_base[WIDTH-1:0];
  assign w_sel_exp  = w_grant ? req_exp[2*WIDTH-1:WIDTH]  : req_exp[WIDTH-1:0];
  assign w_sel_n    = w_grant ? req_n[2*WIDTH-1:WIDTH]    : req_n[WIDTH-1:0];
  assign w_n_zero   = (w_sel_n == '0);
  assign w_e_zero   = (w_sel_exp == '0);
  assign w_degen    = w_n_zero | w_e_zero;
  // Normal jobs also wait for the engine to drain (e.g. after a watchdog abort).
  assign w_accept   = (r_state == c_IDLE) & (|req_valid) & (w_degen | eng_ready);
  assign w_timeout  = (r_wd == c_WD_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_next_state = w_degen ? c_RESP : c_ISSUE;
        end
      end
      c_ISSUE:     w_next_state = c_WAIT_BUSY;
      c_WAIT_BUSY: begin
        // eng_ready can lag the start pulse, so first wait for it to fall.
        if (!eng_ready) begin
          w_next_state = c_WAIT_DONE;
        end else if (w_timeout) begin
          w_next_state = c_RESP;
        end
      end
      c_WAIT_DONE: begin
        if (eng_ready || w_timeout) begin
          w_next_state = c_RESP;
        end
      end
      c_RESP: begin
        if (rsp_ready[r_grant]) begin
          w_next_state = c_IDLE;
        end
      end
      default:     w_next_state = c_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    eng_start = 1'b0;
    if (w_accept) begin
      req_ready = w_grant ? 2'b10 : 2'b01;
    end
    if (r_state == c_RESP) begin
      rsp_valid = r_grant ? 2'b10 : 2'b01;
    end
    if (r_state == c_ISSUE) begin
      eng_start = 1'b1;
    end
  end

  // Job capture, result capture, watchdog and arbitration pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr       <= 1'b0;
      r_grant    <= 1'b0;
      r_base     <= '0;
      r_exp      <= '0;
      r_n        <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_wd       <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_base     <= w_sel_base;
            r_exp      <= w_sel_exp;
            r_n        <= w_sel_n;
            r_grant    <= w_grant;
            r_rr       <= ~w_grant;
            r_rsp_data <= '0;
            r_rsp_err  <= w_n_zero;
            // x^0 mod 1 is 0; x^0 mod n is 1 for any other n.
            if (!w_n_zero && w_e_zero) begin
              r_rsp_data <= (w_sel_n == WIDTH'(1)) ? '0 : WIDTH'(1);
            end
          end
        end
        c_ISSUE: r_wd <= '0;
        c_WAIT_BUSY, c_WAIT_DONE: begin
          if ((r_state == c_WAIT_DONE) && eng_ready) begin
            r_rsp_data <= eng_result;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_wd <= r_wd + c_WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;
  assign eng_base = r_base;
  assign eng_exp  = r_exp;
  assign eng_n    = r_n;

endmodule
`default_nettype wire

// File: tb/tb_modexp_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_modexp_job_arbiter
// Description : Directed bench for modexp_job_arbiter with a behavioural
//               modular-exponentiation engine stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modexp_job_arbiter;

  localparam int W  = 64;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_base;
  logic [2*W-1:0] req_exp;
  logic [2*W-1:0] req_n;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           eng_start;
  logic [W-1:0]   eng_base;
  logic [W-1:0]   eng_exp;
  logic [W-1:0]   eng_n;
  logic [W-1:0]   eng_result;
  logic           eng_ready;

  int vectors     = 0;
  int miscompares = 0;
  int n_starts    = 0;

  logic         stub_hang;
  int           stub_phase;
  int           stub_cnt;
  logic [W-1:0] stub_res;

  always #5 clk = ~clk;

  modexp_job_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_base   (req_base),
    .req_exp    (req_exp),
    .req_n      (req_n),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .eng_start  (eng_start),
    .eng_base   (eng_base),
    .eng_exp    (eng_exp),
    .eng_n      (eng_n),
    .eng_result (eng_result),
    .eng_ready  (eng_ready)
  );

  function automatic logic [W-1:0] f_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] n);
    logic [2*W-1:0] r;
    logic [2*W-1:0] x;
    r = (n == 1) ? '0 : 1;
    x = {{W{1'b0}}, b} % {{W{1'b0}}, n};
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % {{W{1'b0}}, n};
      x = (x * x) % {{W{1'b0}}, n};
    end
    return r[W-1:0];
  endfunction

  // Engine stub: ready lingers 2 cycles after start, then busy 4 cycles
  // (indefinitely while stub_hang is set), then result with ready high.
  always @(posedge clk) begin
    if (eng_start) n_starts <= n_starts + 1;
    if (rst) begin
      eng_ready  <= 1'b1;
      eng_result <= '0;
      stub_phase <= 0;
      stub_cnt   <= 0;
    end else if (eng_start) begin
      stub_phase <= 1;
      stub_cnt   <= 2;
      stub_res   <= f_modexp(eng_base, eng_exp, eng_n);
    end else if (stub_phase == 1) begin
      if (stub_cnt == 1) begin
        eng_ready  <= 1'b0;
        stub_phase <= 2;
        stub_cnt   <= 4;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end else if (stub_phase == 2 && !stub_hang) begin
      if (stub_cnt == 1) begin
        eng_ready  <= 1'b1;
        eng_result <= stub_res;
        stub_phase <= 0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_job(input int ch, input logic [W-1:0] b, input logic [W-1:0] e,
                           input logic [W-1:0] n);
    req_base[ch*W +: W] = b;
    req_exp[ch*W +: W]  = e;
    req_n[ch*W +: W]    = n;
    req_valid[ch]       = 1'b1;
  endtask

  // Waits (bounded) for req_ready[ch], lets the accept edge pass, drops valid.
  task automatic await_accept(input int ch, input string tag);
    int k = 0;
    #1;
    while (!req_ready[ch] && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, {63'd0, req_ready[ch]}, 64'd1);
    @(negedge clk);
    req_valid[ch] = 1'b0;
  endtask

  // Waits (bounded) for a response and checks owner, data and error flag.
  task automatic expect_rsp(input int ch, input logic [W-1:0] data, input logic err,
                            input string tag, output int waited);
    logic [1:0] oh;
    oh     = (ch == 0) ? 2'b01 : 2'b10;
    waited = 0;
    while (rsp_valid == 2'b00 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, ".valid"}, {62'd0, rsp_valid}, {62'd0, oh});
    chk({tag, ".data"}, rsp_data, data);
    chk({tag, ".err"}, {63'd0, rsp_err}, {63'd0, err});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int   w;
    int   s0;
    int   k;
    logic ok;

    rst       = 1'b1;
    req_valid = 2'b00;
    req_base  = '0;
    req_exp   = '0;
    req_n     = '0;
    rsp_ready = 2'b11;
    stub_hang = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst.req_ready", {62'd0, req_ready}, 64'd0);
    chk("rst.rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("rst.rsp_data", rsp_data, 64'd0);
    chk("rst.rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("rst.eng_start", {63'd0, eng_start}, 64'd0);
    chk("rst.eng_base", eng_base, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single normal job on channel 0: 7^5 mod 13 = 11.
    s0 = n_starts;
    drive_job(0, 64'd7, 64'd5, 64'd13);
    await_accept(0, "t1.acc");
    expect_rsp(0, 64'd11, 1'b0, "t1", w);
    chk("t1.starts", 64'(n_starts - s0), 64'd1);
    @(negedge clk);

    // Tie straight after reset: channel 0 first.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_job(0, 64'd23, 64'd8, 64'd97);
    drive_job(1, 64'd2, 64'd10, 64'd7);
    #1;
    chk("tie1.grant", {62'd0, req_ready}, 64'd1);
    await_accept(0, "tie1.acc");
    expect_rsp(0, 64'd16, 1'b0, "tie1", w);
    @(negedge clk);
    // Channel 1 still pending, channel 0 re-requests: channel 1 wins this tie.
    drive_job(0, 64'd7, 64'd5, 64'd13);
    #1;
    chk("tie2.grant", {62'd0, req_ready}, 64'd2);
    await_accept(1, "tie2.acc");
    expect_rsp(1, 64'd2, 1'b0, "tie2", w);
    @(negedge clk);
    await_accept(0, "tie3.acc");
    expect_rsp(0, 64'd11, 1'b0, "tie3", w);
    @(negedge clk);

    // Backpressure on channel 1; channel 0's rsp_ready must be ignored.
    rsp_ready = 2'b01;
    drive_job(1, 64'd3, 64'd4, 64'd5);
    await_accept(1, "hold.acc");
    expect_rsp(1, 64'd1, 1'b0, "hold", w);
    drive_job(0, 64'd5, 64'd0, 64'd7);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 2'b10 || rsp_data !== 64'd1 || rsp_err !== 1'b0 || req_ready !== 2'b00)
        ok = 1'b0;
    end
    chk("hold.stable", {63'd0, ok}, 64'd1);
    rsp_ready = 2'b11;
    @(negedge clk);
    #1;
    chk("hold.released", {62'd0, rsp_valid}, 64'd0);
    chk("hold.idle_ready", {62'd0, req_ready}, 64'd1);

    // Degenerate jobs: answered one cycle after accept, engine untouched.
    s0 = n_starts;
    await_accept(0, "deg1.acc");
    expect_rsp(0, 64'd1, 1'b0, "deg1", w);
    chk("deg1.latency", 64'(w), 64'd0);
    @(negedge clk);
    drive_job(0, 64'd9, 64'd0, 64'd1);
    await_accept(0, "deg2.acc");
    expect_rsp(0, 64'd0, 1'b0, "deg2", w);
    @(negedge clk);
    drive_job(1, 64'd9, 64'd3, 64'd0);
    await_accept(1, "deg3.acc");
    expect_rsp(1, 64'd0, 1'b1, "deg3", w);
    chk("deg.no_start", 64'(n_starts - s0), 64'd0);
    @(negedge clk);

    // Watchdog: the hung engine is observed for TIMEOUT cycles after the
    // start cycle, and the error response appears on the following cycle.
    stub_hang = 1'b1;
    drive_job(0, 64'd7, 64'd5, 64'd13);
    await_accept(0, "to.acc");
    chk("to.start", {63'd0, eng_start}, 64'd1);
    repeat (TO) @(negedge clk);
    chk("to.early", {62'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    chk("to.valid", {62'd0, rsp_valid}, 64'd1);
    chk("to.err", {63'd0, rsp_err}, 64'd1);
    chk("to.data", rsp_data, 64'd0);
    @(negedge clk);
    drive_job(1, 64'd2, 64'd10, 64'd7);
    ok = 1'b1;
    repeat (5) begin
      #1;
      if (req_ready !== 2'b00) ok = 1'b0;
      @(negedge clk);
    end
    chk("to.blocked", {63'd0, ok}, 64'd1);
    stub_hang = 1'b0;
    await_accept(1, "to.reissue");
    expect_rsp(1, 64'd2, 1'b0, "to.after", w);
    @(negedge clk);

    // Reset in WAIT_DONE abandons the job; a later job still works.
    drive_job(0, 64'd12345, 64'd65537, 64'd2168699983);
    await_accept(0, "rj.acc");
    k = 0;
    while (eng_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rj.busy", {63'd0, eng_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rj.rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("rj.rsp_data", rsp_data, 64'd0);
    chk("rj.eng_start", {63'd0, eng_start}, 64'd0);
    chk("rj.eng_exp", eng_exp, 64'd0);
    chk("rj.eng_n", eng_n, 64'd0);
    chk("rj.req_ready", {62'd0, req_ready}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    drive_job(0, 64'd12345, 64'd65537, 64'd2168699983);
    await_accept(0, "rj2.acc");
    expect_rsp(0, 64'd443164720, 1'b0, "rj2", w);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
